// File: rtl/aes_encrypt_rounds.sv
// Iterative AES-128 encryption core. It completes one round every two clocks over a
// shared bank of 16 s-boxes. Round keys come from key_creation and are not latched here.
module aes_encrypt_rounds #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         startEncrypt,
    input  logic         keysValid,
    input  logic [127:0] plainText,
    input  logic [127:0] roundKey1,
    input  logic [127:0] roundKey2,
    input  logic [127:0] roundKey3,
    input  logic [127:0] roundKey4,
    input  logic [127:0] roundKey5,
    input  logic [127:0] roundKey6,
    input  logic [127:0] roundKey7,
    input  logic [127:0] roundKey8,
    input  logic [127:0] roundKey9,
    input  logic [127:0] roundKey10,
    input  logic [127:0] roundKey11,
    output logic [127:0] cipherText,
    output logic         busy,
    output logic         done
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NBYTES = 16;

    typedef enum logic [1:0] {IDLE, SUB, MIX, FINISH} fsm_t;

    fsm_t             fsm_q;
    logic [CNT_W-1:0] round_cnt_q;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] sbox_in_q;

    logic [BLK_W-1:0] shifted_c;
    logic [BLK_W-1:0] sub_c;
    logic [BLK_W-1:0] mixed_c;
    logic [BLK_W-1:0] round_key_c;
    logic [BLK_W-1:0] next_blk_c;
    logic             last_round_c;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as the s-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] s_box(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // ShiftRows: row r of column c takes the byte from column (c + r) mod 4
    always_comb begin
        shifted_c = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted_c[127-32*c-8*r -: 8] = blk_q[127-32*((c+r)%4)-8*r -: 8];
            end
        end
    end

    for (genvar i = 0; i < NBYTES; i++) begin : g_sbox
        assign sub_c[8*i +: 8] = s_box(sbox_in_q[8*i +: 8]);
    end

    always_comb begin
        mixed_c = '0;
        for (int c = 0; c < 4; c++) begin
            mixed_c[127-32*c -: 32] = mix_column(sub_c[127-32*c -: 32]);
        end
    end

    // Round r consumes key r+1
    always_comb begin
        round_key_c = '0;
        case (round_cnt_q)
            4'd1:    round_key_c = roundKey2;
            4'd2:    round_key_c = roundKey3;
            4'd3:    round_key_c = roundKey4;
            4'd4:    round_key_c = roundKey5;
            4'd5:    round_key_c = roundKey6;
            4'd6:    round_key_c = roundKey7;
            4'd7:    round_key_c = roundKey8;
            4'd8:    round_key_c = roundKey9;
            4'd9:    round_key_c = roundKey10;
            4'd10:   round_key_c = roundKey11;
            default: round_key_c = '0;
        endcase
    end

    assign last_round_c = (round_cnt_q == CNT_W'(NUM_ROUNDS));
    assign next_blk_c   = (last_round_c ? sub_c : mixed_c) ^ round_key_c;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fsm_q       <= IDLE;
            round_cnt_q <= '0;
            blk_q       <= '0;
            sbox_in_q   <= '0;
            cipherText  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (startEncrypt && keysValid) begin
                        blk_q       <= plainText ^ roundKey1;
                        round_cnt_q <= CNT_W'(1);
                        busy        <= 1'b1;
                        fsm_q       <= SUB;
                    end
                end
                SUB: begin
                    sbox_in_q <= shifted_c;
                    fsm_q     <= MIX;
                end
                MIX: begin
                    blk_q <= next_blk_c;
                    if (last_round_c) begin
                        fsm_q <= FINISH;
                    end else begin
                        round_cnt_q <= round_cnt_q + CNT_W'(1);
                        fsm_q       <= SUB;
                    end
                end
                FINISH: begin
                    cipherText <= blk_q;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    fsm_q      <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_rounds.sv
// Directed bench for aes_encrypt_rounds that uses the FIPS-197 vectors.
// Round keys are expanded locally from the cipher keys.
module tb_aes_encrypt_rounds;

    typedef logic [10:0][127:0] rk_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_X  = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clock = 1'b0;
    logic         resetN;
    logic         startEncrypt;
    logic         keysValid;
    logic [127:0] plainText;
    rk_t          keys;
    rk_t          keys_b;
    rk_t          keys_c;
    logic [127:0] cipherText;
    logic         busy;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    aes_encrypt_rounds #(.NUM_ROUNDS(10)) dut (
        .clock(clock), .resetN(resetN), .startEncrypt(startEncrypt), .keysValid(keysValid),
        .plainText(plainText),
        .roundKey1(keys[0]), .roundKey2(keys[1]), .roundKey3(keys[2]), .roundKey4(keys[3]),
        .roundKey5(keys[4]), .roundKey6(keys[5]), .roundKey7(keys[6]), .roundKey8(keys[7]),
        .roundKey9(keys[8]), .roundKey10(keys[9]), .roundKey11(keys[10]),
        .cipherText(cipherText), .busy(busy), .done(done)
    );

    function automatic logic [7:0] ref_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = ref_xtime(p);
        end
        return acc;
    endfunction

    // Find the inverse by exhaustive search, then apply the affine map
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (ref_mul(x, 8'(y)) == 8'h01) b = 8'(y);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic rk_t expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         rks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0]), ref_sbox(t[31:24])}
                     ^ {rc, 24'h0};
                rc = ref_xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) rks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return rks;
    endfunction

    // Advances edge by edge until done is seen. Returns the edge count, or 0 if the budget runs out.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; startEncrypt = 1'b0; keysValid = 1'b0; plainText = '0; keys = '0;
        #12;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (cipherText !== '0) begin miscompares++; $display("FAIL reset_ct: got %h want 0", cipherText); end
        resetN = 1'b1;
    endtask

    task automatic test_fips_b();
        int n;
        keys = keys_b; plainText = PT_B; keysValid = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b_busy_after_accept: got %b want 1", busy); end
        wait_done(40, n);
        vectors++; if (n !== 21) begin miscompares++; $display("FAIL b_latency: got %0d want 21", n); end
        vectors++; if (cipherText !== CT_B) begin miscompares++; $display("FAIL b_ct: got %h want %h", cipherText, CT_B); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b_busy_at_done: got %b want 0", busy); end
        @(posedge clock); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b_done_one_cycle: got %b want 0", done); end
        vectors++; if (cipherText !== CT_B) begin miscompares++; $display("FAIL b_ct_held: got %h want %h", cipherText, CT_B); end
    endtask

    task automatic test_fips_c();
        int n;
        keys = keys_c; plainText = PT_C; keysValid = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b0;
        wait_done(40, n);
        vectors++; if (n !== 21) begin miscompares++; $display("FAIL c_latency: got %0d want 21", n); end
        vectors++; if (cipherText !== CT_C) begin miscompares++; $display("FAIL c_ct: got %h want %h", cipherText, CT_C); end
    endtask

    task automatic test_keys_invalid();
        int n;
        logic seen;
        keys = keys_b; plainText = PT_B; keysValid = 1'b0;
        @(posedge clock); #1; startEncrypt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL nokeys_ignored: got activity %b want 0", seen); end
        keysValid = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL nokeys_accept: got busy %b want 1", busy); end
        wait_done(40, n);
        vectors++; if (n !== 21) begin miscompares++; $display("FAIL nokeys_latency: got %0d want 21", n); end
        vectors++; if (cipherText !== CT_B) begin miscompares++; $display("FAIL nokeys_ct: got %h want %h", cipherText, CT_B); end
    endtask

    task automatic test_start_while_busy();
        int dones;
        int first;
        logic [127:0] ct_seen;
        keys = keys_b; plainText = PT_B; keysValid = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b0;
        dones = 0; first = 0; ct_seen = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (i == 4) begin startEncrypt = 1'b1; plainText = PT_X; end
            if (i == 5) startEncrypt = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (first == 0) begin first = i; ct_seen = cipherText; end
            end
        end
        vectors++; if (dones !== 1) begin miscompares++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
        vectors++; if (first !== 21) begin miscompares++; $display("FAIL busy_start_latency: got %0d want 21", first); end
        vectors++; if (ct_seen !== CT_B) begin miscompares++; $display("FAIL busy_start_ct: got %h want %h", ct_seen, CT_B); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        keys = keys_c; plainText = PT_C; keysValid = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b0;
        for (int i = 1; i <= 9; i++) begin @(posedge clock); #1; end
        @(posedge clock); #2;
        resetN = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b want 0", done); end
        vectors++; if (cipherText !== '0) begin miscompares++; $display("FAIL midrst_ct: got %h want 0", cipherText); end
        @(posedge clock); @(negedge clock);
        resetN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done: got activity %b want 0", seen); end
        keys = keys_b; plainText = PT_B;
        @(posedge clock); #1; startEncrypt = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b0;
        wait_done(40, n);
        vectors++; if (n !== 21) begin miscompares++; $display("FAIL midrst_latency: got %0d want 21", n); end
        vectors++; if (cipherText !== CT_B) begin miscompares++; $display("FAIL midrst_ct_after: got %h want %h", cipherText, CT_B); end
    endtask

    task automatic test_back_to_back();
        int n;
        keys = keys_b; plainText = PT_B; keysValid = 1'b1;
        @(posedge clock); #1; startEncrypt = 1'b1;
        @(posedge clock); #1;
        wait_done(40, n);
        vectors++; if (n !== 21) begin miscompares++; $display("FAIL b2b_first_latency: got %0d want 21", n); end
        vectors++; if (cipherText !== CT_B) begin miscompares++; $display("FAIL b2b_ct1: got %h want %h", cipherText, CT_B); end
        keys = keys_c; plainText = PT_C;
        wait_done(40, n);
        vectors++; if (n !== 22) begin miscompares++; $display("FAIL b2b_interval1: got %0d want 22", n); end
        vectors++; if (cipherText !== CT_C) begin miscompares++; $display("FAIL b2b_ct2: got %h want %h", cipherText, CT_C); end
        keys = keys_b; plainText = PT_B;
        wait_done(40, n);
        startEncrypt = 1'b0;
        vectors++; if (n !== 22) begin miscompares++; $display("FAIL b2b_interval2: got %0d want 22", n); end
        vectors++; if (cipherText !== CT_B) begin miscompares++; $display("FAIL b2b_ct3: got %h want %h", cipherText, CT_B); end
    endtask

    initial begin
        keys_b = expand_key(KEY_B);
        keys_c = expand_key(KEY_C);
        test_reset();
        test_fips_b();
        test_fips_c();
        test_keys_invalid();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
